// File: rtl/laser_cover_check_if.sv
// Point stream, placement-stage centers and coverage results exchanged with laser_cover_check.
interface laser_cover_check_if;
    logic       IN_VALID;
    logic [3:0] X;
    logic [3:0] Y;
    logic       DONE_IN;
    logic [3:0] C1X;
    logic [3:0] C1Y;
    logic [3:0] C2X;
    logic [3:0] C2Y;
    logic [5:0] COVER;
    logic [5:0] OVL;
    logic       CHK_DONE;
    logic       BUSY;

    modport master (
        output IN_VALID, X, Y, DONE_IN, C1X, C1Y, C2X, C2Y,
        input  COVER, OVL, CHK_DONE, BUSY
    );

    modport slave (
        input  IN_VALID, X, Y, DONE_IN, C1X, C1Y, C2X, C2Y,
        output COVER, OVL, CHK_DONE, BUSY
    );
endinterface

// File: rtl/laser_cover_check.sv
// Buffers 40 target points, then counts how many fall inside the union and the
// intersection of the two radius-4 laser circles reported by the placement stage.
module laser_cover_check (
    input  logic                 CLK,
    input  logic                 RST,
    laser_cover_check_if.slave   bus
);
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        WAIT = 3'd2,
        EVAL = 3'd3,
        OUT  = 3'd4
    } state_t;

    localparam logic [5:0] LAST_IDX = 6'd39;

    state_t     state_r;
    state_t     state_s;
    logic [5:0] idx_r;
    logic [7:0] pt_mem_r [0:39];
    logic [3:0] c1x_r, c1y_r, c2x_r, c2y_r;
    logic [5:0] union_acc_r, ovl_acc_r;
    logic [5:0] cover_r, ovl_r;
    logic       chk_done_r, busy_r;
    logic [7:0] pt_s;
    logic       hit1_s, hit2_s, union_inc_s, ovl_inc_s;

    // Full-precision distance test: squares need 8 bits, their sum needs 9.
    function automatic logic in_circle(input logic [3:0] px, input logic [3:0] py,
                                       input logic [3:0] cx, input logic [3:0] cy);
        logic [3:0] dx, dy;
        logic [7:0] dx2, dy2;
        logic [8:0] d2;
        dx  = (px >= cx) ? (px - cx) : (cx - px);
        dy  = (py >= cy) ? (py - cy) : (cy - py);
        dx2 = {4'd0, dx} * {4'd0, dx};
        dy2 = {4'd0, dy} * {4'd0, dy};
        d2  = {1'b0, dx2} + {1'b0, dy2};
        return (d2 <= 9'd16);
    endfunction

    // State register.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic and per-point hit evaluation.
    always_comb begin
        state_s     = state_r;
        pt_s        = pt_mem_r[idx_r];
        hit1_s      = in_circle(pt_s[7:4], pt_s[3:0], c1x_r, c1y_r);
        hit2_s      = in_circle(pt_s[7:4], pt_s[3:0], c2x_r, c2y_r);
        union_inc_s = hit1_s | hit2_s;
        ovl_inc_s   = hit1_s & hit2_s;
        case (state_r)
            IDLE: state_s = LOAD;
            LOAD: begin
                if (bus.IN_VALID && (idx_r == LAST_IDX)) begin
                    state_s = WAIT;
                end else begin
                    state_s = LOAD;
                end
            end
            WAIT: begin
                if (bus.DONE_IN) begin
                    state_s = EVAL;
                end else begin
                    state_s = WAIT;
                end
            end
            EVAL: begin
                if (idx_r == LAST_IDX) begin
                    state_s = OUT;
                end else begin
                    state_s = EVAL;
                end
            end
            OUT:     state_s = LOAD;
            default: state_s = IDLE;
        endcase
    end

    // Point buffer; never reset because a full set always reloads before evaluation.
    always_ff @(posedge CLK) begin
        if ((state_r == LOAD) && bus.IN_VALID) begin
            pt_mem_r[idx_r] <= {bus.X, bus.Y};
        end
    end

    // Index, latched centers, accumulators and registered outputs.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            idx_r       <= 6'd0;
            c1x_r       <= 4'd0;
            c1y_r       <= 4'd0;
            c2x_r       <= 4'd0;
            c2y_r       <= 4'd0;
            union_acc_r <= 6'd0;
            ovl_acc_r   <= 6'd0;
            cover_r     <= 6'd0;
            ovl_r       <= 6'd0;
            chk_done_r  <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            chk_done_r <= (state_s == OUT);
            busy_r     <= (state_s == EVAL);
            case (state_r)
                LOAD: begin
                    if (bus.IN_VALID) begin
                        idx_r <= (idx_r == LAST_IDX) ? 6'd0 : (idx_r + 6'd1);
                    end
                end
                WAIT: begin
                    if (bus.DONE_IN) begin
                        c1x_r       <= bus.C1X;
                        c1y_r       <= bus.C1Y;
                        c2x_r       <= bus.C2X;
                        c2y_r       <= bus.C2Y;
                        union_acc_r <= 6'd0;
                        ovl_acc_r   <= 6'd0;
                        idx_r       <= 6'd0;
                    end
                end
                EVAL: begin
                    union_acc_r <= union_acc_r + {5'd0, union_inc_s};
                    ovl_acc_r   <= ovl_acc_r + {5'd0, ovl_inc_s};
                    if (idx_r == LAST_IDX) begin
                        idx_r   <= 6'd0;
                        cover_r <= union_acc_r + {5'd0, union_inc_s};
                        ovl_r   <= ovl_acc_r + {5'd0, ovl_inc_s};
                    end else begin
                        idx_r <= idx_r + 6'd1;
                    end
                end
                default: begin
                    idx_r <= idx_r;
                end
            endcase
        end
    end

    assign bus.COVER    = cover_r;
    assign bus.OVL      = ovl_r;
    assign bus.CHK_DONE = chk_done_r;
    assign bus.BUSY     = busy_r;
endmodule

// File: doc/laser_cover_check.md
LASER_COVER_CHECK -- requirements
Module: laser_cover_check

Interface
REQ-001 SHALL have port CLK, input, 1 bit: single clock; all state updates on the rising edge.
REQ-002 SHALL have port RST, input, 1 bit: asynchronous, active-low reset; 0 = reset.
REQ-003 SHALL have port IN_VALID, input, 1 bit: X/Y carry a target point this cycle.
REQ-004 SHALL have ports X and Y, inputs, 4 bits each: target coordinates on the 16x16 grid, same stream that feeds the laser-placement stage.
REQ-005 SHALL have port DONE_IN, input, 1 bit: placement stage's DONE; centers are valid in any cycle it is 1.
REQ-006 SHALL have ports C1X, C1Y, C2X and C2Y, inputs, 4 bits each: circle centers from the placement stage.
REQ-007 SHALL have port COVER, output, 6 bits: count of points inside C1 or C2 (union).
REQ-008 SHALL have port OVL, output, 6 bits: count of points inside both C1 and C2.
REQ-009 SHALL have port CHK_DONE, output, 1 bit: one-cycle pulse; COVER/OVL final.
REQ-010 SHALL have port BUSY, output, 1 bit: 1 while in EVAL.

Function
REQ-011 SHALL implement FSM states IDLE, LOAD, WAIT, EVAL, OUT; IDLE goes to LOAD in the first cycle after reset release.
REQ-012 SHALL, in LOAD, store X/Y into a 40-entry buffer at index 0..39 (6-bit counter) on each cycle with IN_VALID=1; cycles with IN_VALID=0 are gaps and SHALL NOT advance the index.
REQ-013 SHALL move LOAD to WAIT on the edge storing entry 39; counter SHALL then return to 0.
REQ-014 SHALL ignore IN_VALID in WAIT, EVAL and OUT; SHALL ignore DONE_IN in IDLE, LOAD, EVAL and OUT.
REQ-015 SHALL, in WAIT, latch C1X/C1Y/C2X/C2Y and clear the internal accumulators on the edge where DONE_IN=1, then enter EVAL.
REQ-016 SHALL, in EVAL, test one buffered point per cycle, index 0..39, 40 cycles total, using the latched centers only.
REQ-017 SHALL treat point inside circle iff dx*dx + dy*dy <= 16, dx = |px - cx| and dy = |py - cy| (4-bit unsigned), squares 8-bit, sum 9-bit, no truncation; boundary (distance exactly 4) counts as inside.
REQ-018 SHALL increment the union accumulator if inside C1 or C2, and the overlap accumulator if inside both; duplicate points SHALL count separately; max value 40.
REQ-019 SHALL enter OUT after the 40th EVAL cycle; in OUT, COVER/OVL SHALL show final counts and CHK_DONE=1 for exactly one cycle; next state LOAD.
REQ-020 Latency: DONE_IN sampled high at end of cycle k -> EVAL cycles k+1..k+40 -> CHK_DONE=1 in cycle k+41.
REQ-021 SHALL register COVER/OVL and update them only on entry to OUT; they hold until the next entry to OUT or reset.
REQ-022 SHALL treat identical centers normally (COVER = OVL); centers near the grid edge need no clipping.
REQ-023 SHALL set BUSY=1 exactly during the 40 EVAL cycles.
REQ-024 SHALL accept back-to-back sets: LOAD for the next set starts the cycle after OUT.

Reset
REQ-025 SHALL, on RST=0 in any state including mid-LOAD or mid-EVAL, immediately force state IDLE, all counters/accumulators 0, COVER=0, OVL=0, CHK_DONE=0, BUSY=0.
REQ-026 SHALL NOT require buffer contents to be cleared; SHALL NOT make any output depend on stale buffer data after reset, since 40 new points load before any evaluation.

Verification
REQ-027 Scenario: 40 points all (8,8), DONE_IN with C1=(8,8), C2=(0,0) -> COVER=40, OVL=0, CHK_DONE 41 cycles after DONE_IN.
REQ-028 Scenario: C1=(0,0), C2=(15,15); 20 points (4,0), 20 points (3,3) -> COVER=20, OVL=0 (16 inside, 18 outside).
REQ-029 Scenario: C1=C2=(5,5); 25 points (5,7), 15 points (12,12) -> COVER=25, OVL=25.
REQ-030 Scenario: 40 points with random IN_VALID gaps plus a DONE_IN pulse during LOAD -> pulse ignored, result identical to gap-free load of the same points.
REQ-031 Scenario: RST=0 at EVAL cycle 20 -> all outputs 0 immediately; fresh 40-point set plus DONE_IN -> correct counts.
REQ-032 Scenario: two sets back-to-back, second with C1=(15,0), C2=(0,15), all points (7,7) -> first result held until second OUT; second COVER=0, OVL=0.
